pipe_tag_tracker: RTL and testbench

Parametrised verification-side transaction tracker for an N-stage in-order pipeline; it supersedes the fixed five-stage per-stage tag counters in the core top level. A monotonically incrementing tag is allocated at stage 0 and moves stage to stage on per-stage advance strobes. Valid bits track occupancy, per-stage flushes are honoured, and token-loss and retire-order violations are detected. The block sits beside the core in the verification top and drives property checkers and scoreboards only; it never feeds back into the datapath.

---
 rtl/pipe_tag_pkg.sv | 29 ++
 rtl/pipe_tag_stage.sv | 67 ++++++
 rtl/pipe_tag_tracker.sv | 134 +++++++++++++
 tb/tb_pipe_tag_tracker.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/pipe_tag_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_tag_pkg
//  Description : Shared defaults and modular tag-ordering helper for the
//                pipeline tag tracker.
//  Revision    : 1.0 - initial release
// ============================================================================
package pipe_tag_pkg;

   localparam int c_DEF_STAGES  = 5;
   localparam int c_DEF_TAG_W   = 6;
   localparam int c_DEF_STALL_W = 8;

   // True when tag a is strictly newer than tag b, within half the tag space
   // of a w-bit wrapping counter.
   function automatic logic tag_after(input logic [31:0] a,
                                      input logic [31:0] b,
                                      input int          w);
      logic [31:0] mask;
      logic [31:0] half;
      logic [31:0] d;
      mask = (32'd1 << w) - 32'd1;
      half = 32'd1 << (w - 1);
      d    = (a - b) & mask;
      return (d != 32'd0) && (d < half);
   endfunction

endpackage : pipe_tag_pkg
`default_nettype wire

// File: rtl/pipe_tag_stage.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_tag_stage
//  Description : One tracked pipeline stage: tag/valid register plus an
//                optional wait counter (enabled by PIPE_TAG_STALL_CNT_EN).
//  Revision    : 1.0 - initial release
// ============================================================================
module pipe_tag_stage
   import pipe_tag_pkg::*;
#(
   parameter int TAG_W   = c_DEF_TAG_W,
   parameter int STALL_W = c_DEF_STALL_W
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               cap,
   input  logic               leave,
   input  logic               flush,
   input  logic [TAG_W-1:0]   src_tag,
   input  logic               src_vld,
   output logic [TAG_W-1:0]   tag,
   output logic               vld,
   output logic [STALL_W-1:0] stall_cnt
);

   logic [TAG_W-1:0] r_tag;
   logic             r_vld;

   // Capture takes the upstream token; flush always wins on the valid bit,
   // and a departure without a new capture leaves a bubble (tag held).
   always_ff @(posedge clk) begin
      if (rst) begin
         r_tag <= '0;
         r_vld <= 1'b0;
      end else if (cap) begin
         r_tag <= src_tag;
         r_vld <= src_vld & ~flush;
      end else if (leave || flush) begin
         r_vld <= 1'b0;
      end
   end

   assign tag = r_tag;
   assign vld = r_vld;

`ifdef PIPE_TAG_STALL_CNT_EN
   localparam logic [STALL_W-1:0] c_STALL_MAX = '1;
   logic [STALL_W-1:0] r_stall;

   // Saturating count of cycles the resident token has waited here.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_stall <= '0;
      end else if (cap || leave || flush) begin
         r_stall <= '0;
      end else if (r_vld && (r_stall != c_STALL_MAX)) begin
         r_stall <= r_stall + STALL_W'(1);
      end
   end

   assign stall_cnt = r_stall;
`else
   assign stall_cnt = '0;
`endif

endmodule : pipe_tag_stage
`default_nettype wire

// File: rtl/pipe_tag_tracker.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_tag_tracker
//  Description : Verification-side tag tracker for an N-stage in-order
//                pipeline: tag allocation, per-stage valid/flush tracking,
//                retire reporting, token-loss and retire-order checks.
//                Optional per-stage wait counters: PIPE_TAG_STALL_CNT_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module pipe_tag_tracker
   import pipe_tag_pkg::*;
#(
   parameter int STAGES  = c_DEF_STAGES,
   parameter int TAG_W   = c_DEF_TAG_W,
   parameter int STALL_W = c_DEF_STALL_W
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [STAGES-1:0]          adv,
   input  logic [STAGES-1:0]          flush,
   input  logic                       ret,
   output logic [STAGES*TAG_W-1:0]    tag,
   output logic [STAGES-1:0]          vld,
   output logic [TAG_W-1:0]           next_tag,
   output logic                       retire_vld,
   output logic [TAG_W-1:0]           retire_tag,
   output logic                       lost_err,
   output logic                       order_err,
   output logic [STAGES*STALL_W-1:0]  stall_cnt
);

   localparam int c_LAST = STAGES - 1;

   logic [TAG_W-1:0]  r_next_tag;
   logic              r_retire_vld;
   logic [TAG_W-1:0]  r_retire_tag;
   logic              r_lost_err;
   logic              r_order_err;
   logic              r_first;
   logic [TAG_W-1:0]  r_last_ret;

   logic [TAG_W-1:0]  w_tag     [STAGES];
   logic [TAG_W-1:0]  w_src_tag [STAGES];
   logic [STAGES-1:0] w_src_vld;
   logic [STAGES-1:0] w_leave;
   logic              w_retire;
   logic              w_lost;
   logic              w_order_bad;

   genvar s;
   generate
      for (s = 0; s < STAGES; s++) begin : g_stage
         if (s == 0) begin : g_head
            assign w_src_tag[s] = r_next_tag;
            assign w_src_vld[s] = 1'b1;
         end else begin : g_body
            assign w_src_tag[s] = w_tag[s-1];
            assign w_src_vld[s] = vld[s-1];
         end

         if (s == c_LAST) begin : g_tail
            assign w_leave[s] = ret & vld[s];
         end else begin : g_mid
            assign w_leave[s] = adv[s+1];
         end

         pipe_tag_stage #(
            .TAG_W   (TAG_W),
            .STALL_W (STALL_W)
         ) u_stage (
            .clk       (clk),
            .rst       (rst),
            .cap       (adv[s]),
            .leave     (w_leave[s]),
            .flush     (flush[s]),
            .src_tag   (w_src_tag[s]),
            .src_vld   (w_src_vld[s]),
            .tag       (w_tag[s]),
            .vld       (vld[s]),
            .stall_cnt (stall_cnt[s*STALL_W +: STALL_W])
         );

         assign tag[s*TAG_W +: TAG_W] = w_tag[s];
      end
   endgenerate

   // A live, unflushed token overwritten by a capture that did not move it on.
   assign w_lost      = |(adv & vld & ~flush & ~w_leave);
   assign w_retire    = ret & vld[c_LAST] & ~flush[c_LAST];
   assign w_order_bad = ~r_first &
                        ~tag_after(32'(w_tag[c_LAST]), 32'(r_last_ret), TAG_W);

   // Allocator: each stage-0 capture consumes one tag.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_next_tag <= '0;
      end else if (adv[0]) begin
         r_next_tag <= r_next_tag + TAG_W'(1);
      end
   end

   // Retire reporting, order tracking and sticky error flags.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_retire_vld <= 1'b0;
         r_retire_tag <= '0;
         r_lost_err   <= 1'b0;
         r_order_err  <= 1'b0;
         r_first      <= 1'b1;
         r_last_ret   <= '0;
      end else begin
         r_retire_vld <= w_retire;
         if (w_lost) begin
            r_lost_err <= 1'b1;
         end
         if (w_retire) begin
            r_retire_tag <= w_tag[c_LAST];
            r_last_ret   <= w_tag[c_LAST];
            r_first      <= 1'b0;
            if (w_order_bad) begin
               r_order_err <= 1'b1;
            end
         end
      end
   end

   assign next_tag   = r_next_tag;
   assign retire_vld = r_retire_vld;
   assign retire_tag = r_retire_tag;
   assign lost_err   = r_lost_err;
   assign order_err  = r_order_err;

endmodule : pipe_tag_tracker
`default_nettype wire

// File: tb/tb_pipe_tag_tracker.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pipe_tag_tracker
//  Description : Randomised self-checking bench for pipe_tag_tracker against
//                a token-level reference model (narrow tags to force wrap).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_tag_tracker;

   localparam int STAGES  = 5;
   localparam int TAG_W   = 3;
   localparam int STALL_W = 2;
   localparam int LAST    = STAGES - 1;
   localparam int TAG_MOD = 1 << TAG_W;
   localparam int ST_MAX  = (1 << STALL_W) - 1;
   localparam int N_CYC   = 4000;

   logic                      clk = 1'b0;
   logic                      rst;
   logic [STAGES-1:0]         adv;
   logic [STAGES-1:0]         flush;
   logic                      ret;
   logic [STAGES*TAG_W-1:0]   tag;
   logic [STAGES-1:0]         vld;
   logic [TAG_W-1:0]          next_tag;
   logic                      retire_vld;
   logic [TAG_W-1:0]          retire_tag;
   logic                      lost_err;
   logic                      order_err;
   logic [STAGES*STALL_W-1:0] stall_cnt;

   pipe_tag_tracker #(
      .STAGES  (STAGES),
      .TAG_W   (TAG_W),
      .STALL_W (STALL_W)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .adv        (adv),
      .flush      (flush),
      .ret        (ret),
      .tag        (tag),
      .vld        (vld),
      .next_tag   (next_tag),
      .retire_vld (retire_vld),
      .retire_tag (retire_tag),
      .lost_err   (lost_err),
      .order_err  (order_err),
      .stall_cnt  (stall_cnt)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference model: one token slot per stage, tracked as plain integers.
   int m_vld  [STAGES];
   int m_tag  [STAGES];
   int m_wait [STAGES];
   int m_next, m_rv, m_rt, m_lost, m_order, m_first, m_lastret;
   int n_retires, n_order_evts, n_lost_evts;

   task automatic model_reset();
      for (int i = 0; i < STAGES; i++) begin
         m_vld[i] = 0; m_tag[i] = 0; m_wait[i] = 0;
      end
      m_next = 0; m_rv = 0; m_rt = 0; m_lost = 0; m_order = 0;
      m_first = 1; m_lastret = 0;
   endtask

   task automatic model_step(input logic [STAGES-1:0] a, input logic [STAGES-1:0] f,
                             input logic r, input logic rs);
      int nv [STAGES];
      int nt [STAGES];
      int nw [STAGES];
      int leaving;
      int d;
      if (rs) begin
         model_reset();
         return;
      end
      for (int i = 0; i < STAGES; i++) begin
         leaving = (i < LAST) ? int'(a[i+1]) : int'(r && m_vld[LAST] != 0);
         if (a[i]) begin
            nt[i] = (i == 0) ? m_next : m_tag[i-1];
            nv[i] = ((i == 0) ? 1 : m_vld[i-1]) & int'(!f[i]);
            if (m_vld[i] != 0 && !f[i] && leaving == 0) begin
               m_lost = 1;
               n_lost_evts++;
            end
         end else begin
            nt[i] = m_tag[i];
            nv[i] = (m_vld[i] != 0 && leaving == 0 && !f[i]) ? 1 : 0;
         end
`ifdef PIPE_TAG_STALL_CNT_EN
         if (a[i] || leaving != 0 || f[i]) nw[i] = 0;
         else if (m_vld[i] != 0)           nw[i] = (m_wait[i] < ST_MAX) ? m_wait[i] + 1 : ST_MAX;
         else                              nw[i] = m_wait[i];
`else
         nw[i] = 0;
`endif
      end
      m_rv = 0;
      if (r && m_vld[LAST] != 0 && !f[LAST]) begin
         m_rv = 1;
         m_rt = m_tag[LAST];
         n_retires++;
         if (m_first == 0) begin
            d = (m_tag[LAST] - m_lastret + TAG_MOD) % TAG_MOD;
            if (d == 0 || d >= TAG_MOD / 2) begin
               m_order = 1;
               n_order_evts++;
            end
         end
         m_first   = 0;
         m_lastret = m_tag[LAST];
      end
      if (a[0]) m_next = (m_next + 1) % TAG_MOD;
      for (int i = 0; i < STAGES; i++) begin
         m_vld[i] = nv[i]; m_tag[i] = nt[i]; m_wait[i] = nw[i];
      end
   endtask

   task automatic compare_all();
      logic [STAGES*TAG_W-1:0]   e_tag;
      logic [STAGES-1:0]         e_vld;
      logic [STAGES*STALL_W-1:0] e_st;
      for (int i = 0; i < STAGES; i++) begin
         e_tag[i*TAG_W +: TAG_W]     = TAG_W'(m_tag[i]);
         e_vld[i]                    = (m_vld[i] != 0);
         e_st[i*STALL_W +: STALL_W]  = STALL_W'(m_wait[i]);
      end
      check("tag",        64'(tag),        64'(e_tag));
      check("vld",        64'(vld),        64'(e_vld));
      check("next_tag",   64'(next_tag),   64'(m_next));
      check("retire_vld", 64'(retire_vld), 64'(m_rv));
      check("retire_tag", 64'(retire_tag), 64'(m_rt));
      check("lost_err",   64'(lost_err),   64'(m_lost));
      check("order_err",  64'(order_err),  64'(m_order));
      check("stall_cnt",  64'(stall_cnt),  64'(e_st));
   endtask

   initial begin
      logic [STAGES-1:0] a, f;
      logic              r, rs;
      int                lv;
      n_retires = 0; n_order_evts = 0; n_lost_evts = 0;
      rst = 1'b1; adv = '0; flush = '0; ret = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check("reset_vld",       64'(vld),       64'd0);
      check("reset_tag",       64'(tag),       64'd0);
      check("reset_next_tag",  64'(next_tag),  64'd0);
      check("reset_errs",      64'({lost_err, order_err, retire_vld}), 64'd0);
      check("reset_stall",     64'(stall_cnt), 64'd0);
      rst = 1'b0;

      for (int c = 0; c < N_CYC; c++) begin
         // Mostly well-formed traffic with occasional overwrites, flushes and resets.
         r  = ($urandom_range(9) < 6);
         rs = ($urandom_range(79) == 0);
         for (int i = LAST; i >= 0; i--) begin
            lv = (i < LAST) ? int'(a[i+1]) : int'(r && m_vld[LAST] != 0);
            if (m_vld[i] == 0 || lv != 0) a[i] = ($urandom_range(3) != 0);
            else                          a[i] = ($urandom_range(39) == 0);
            f[i] = ($urandom_range(24) == 0);
         end
         adv = a; flush = f; ret = r; rst = rs;
         model_step(a, f, r, rs);
         @(posedge clk);
         #1;
         compare_all();
      end

      check("saw_retires", 64'(n_retires > 50),   64'd1);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule : tb_pipe_tag_tracker
`default_nettype wire
